// File: rtl/intersection_scheduler.sv
// Two-road intersection sequencer: main road, side road with car sensor and a pedestrian walk
// phase, all timed from one shared phase counter.
module intersection_scheduler #(
    parameter int unsigned T_MIN_GRN  = 10000,
    parameter int unsigned T_YLW      = 3000,
    parameter int unsigned T_ALL_RED  = 1000,
    parameter int unsigned T_SIDE_GRN = 5000,
    parameter int unsigned T_WALK     = 4000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CAR,
    input  logic       PED,
    output logic       M_GRN,
    output logic       M_YLW,
    output logic       M_RED,
    output logic       S_GRN,
    output logic       S_YLW,
    output logic       S_RED,
    output logic       WALK,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        StMainGrn = 3'd0,
        StMainYlw = 3'd1,
        StAllRed1 = 3'd2,
        StSideGrn = 3'd3,
        StSideYlw = 3'd4,
        StAllRed2 = 3'd5,
        StWalk    = 3'd6,
        StIllegal = 3'd7
    } state_e;

    // Last count value of each timed phase; a phase of T cycles exits at count T-1.
    localparam logic [CNT_W-1:0] MinGrnLast  = CNT_W'(T_MIN_GRN - 1);
    localparam logic [CNT_W-1:0] YlwLast     = CNT_W'(T_YLW - 1);
    localparam logic [CNT_W-1:0] AllRedLast  = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] SideGrnLast = CNT_W'(T_SIDE_GRN - 1);
    localparam logic [CNT_W-1:0] WalkLast    = CNT_W'(T_WALK - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             car_pend_q, car_pend_d;
    logic             ped_pend_q, ped_pend_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StMainGrn: begin
                if (cnt_q == MinGrnLast && (car_pend_q || ped_pend_q)) begin
                    state_d = StMainYlw;
                end
            end
            StMainYlw: begin
                if (cnt_q == YlwLast) begin
                    state_d = StAllRed1;
                end
            end
            StAllRed1: begin
                // Car is served ahead of the pedestrian when both are waiting.
                if (cnt_q == AllRedLast) begin
                    if (car_pend_q) begin
                        state_d = StSideGrn;
                    end else if (ped_pend_q) begin
                        state_d = StWalk;
                    end else begin
                        state_d = StMainGrn;
                    end
                end
            end
            StSideGrn: begin
                if (cnt_q == SideGrnLast) begin
                    state_d = StSideYlw;
                end
            end
            StSideYlw: begin
                if (cnt_q == YlwLast) begin
                    state_d = StAllRed2;
                end
            end
            StAllRed2: begin
                if (cnt_q == AllRedLast) begin
                    state_d = ped_pend_q ? StWalk : StMainGrn;
                end
            end
            StWalk: begin
                if (cnt_q == WalkLast) begin
                    state_d = StMainGrn;
                end
            end
            default: state_d = StMainGrn;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == StMainGrn && cnt_q == MinGrnLast) begin
            // Hold at the end of minimum green so a late request is served at once.
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        car_pend_d = car_pend_q | (CAR & (state_q != StSideGrn) & (state_q != StSideYlw));
        ped_pend_d = ped_pend_q | (PED & (state_q != StWalk));
        // Entering the service phase clears the request, overriding a same-cycle set.
        if (state_d == StSideGrn && state_q != StSideGrn) begin
            car_pend_d = 1'b0;
        end
        if (state_d == StWalk && state_q != StWalk) begin
            ped_pend_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q    <= StMainGrn;
            cnt_q      <= '0;
            car_pend_q <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            car_pend_q <= car_pend_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        M_GRN = 1'b0;
        M_YLW = 1'b0;
        M_RED = 1'b1;
        S_GRN = 1'b0;
        S_YLW = 1'b0;
        S_RED = 1'b1;
        WALK  = 1'b0;
        case (state_q)
            StMainGrn: begin
                M_GRN = 1'b1;
                M_RED = 1'b0;
            end
            StMainYlw: begin
                M_YLW = 1'b1;
                M_RED = 1'b0;
            end
            StSideGrn: begin
                S_GRN = 1'b1;
                S_RED = 1'b0;
            end
            StSideYlw: begin
                S_YLW = 1'b1;
                S_RED = 1'b0;
            end
            StWalk:  WALK = 1'b1;
            default: ;
        endcase
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed and randomized bench for intersection_scheduler, checked against a phase-table
// reference model with short test timings.
module tb_intersection_scheduler;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       CAR   = 1'b0;
    logic       PED   = 1'b0;
    logic       M_GRN, M_YLW, M_RED, S_GRN, S_YLW, S_RED, WALK;
    logic [2:0] STATE;
    logic [6:0] lamp_vec;

    int checks  = 0;
    int errors  = 0;
    int edge_no = 0;

    // Reference model: phase number, cycles spent in it, and pending requests.
    int m_st = 0;
    int m_el = 0;
    bit m_cp = 0;
    bit m_pp = 0;
    // Phase durations, index = phase; entry 0 is the minimum main green.
    int dur[7] = '{8, 3, 2, 5, 3, 2, 4};

    intersection_scheduler #(
        .T_MIN_GRN (8),
        .T_YLW     (3),
        .T_ALL_RED (2),
        .T_SIDE_GRN(5),
        .T_WALK    (4),
        .CNT_W     (16)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .CAR  (CAR),
        .PED  (PED),
        .M_GRN(M_GRN),
        .M_YLW(M_YLW),
        .M_RED(M_RED),
        .S_GRN(S_GRN),
        .S_YLW(S_YLW),
        .S_RED(S_RED),
        .WALK (WALK),
        .STATE(STATE)
    );

    assign lamp_vec = {M_GRN, M_YLW, M_RED, S_GRN, S_YLW, S_RED, WALK};

    always #5 Clock = ~Clock;

    function automatic logic [6:0] lamps(input int s);
        logic sg, sy;
        sg = (s == 3);
        sy = (s == 4);
        return {s == 0, s == 1, s > 1, sg, sy, !(sg || sy), s == 6};
    endfunction

    task automatic model_step(input bit c, input bit p, input bit r);
        int  nx;
        bit  cp, pp;
        if (!r) begin
            m_st = 0; m_el = 0; m_cp = 0; m_pp = 0;
            return;
        end
        nx = m_st;
        if (m_st == 0) begin
            if (m_el >= dur[0] - 1 && (m_cp || m_pp)) nx = 1;
        end else if (m_el + 1 >= dur[m_st]) begin
            case (m_st)
                1:       nx = 2;
                2:       nx = m_cp ? 3 : (m_pp ? 6 : 0);
                3:       nx = 4;
                4:       nx = 5;
                5:       nx = m_pp ? 6 : 0;
                default: nx = 0;
            endcase
        end
        cp = (m_cp || (c && m_st != 3 && m_st != 4)) && !(nx == 3 && m_st != 3);
        pp = (m_pp || (p && m_st != 6)) && !(nx == 6 && m_st != 6);
        m_cp = cp;
        m_pp = pp;
        m_el = (nx != m_st) ? 0 : m_el + 1;
        m_st = nx;
    endtask

    // Drive inputs for the next edge, advance model, then sample #1 after the edge.
    task automatic step(input bit c, input bit p, input bit r);
        CAR = c; PED = p; Reset = r;
        @(posedge Clock);
        model_step(c, p, r);
        if (!r) edge_no = 0;
        else edge_no++;
        #1;
        checks++;
        assert (STATE === 3'(m_st)) else begin
            errors++;
            $error("FAIL model_state edge %0d: got %0d want %0d", edge_no, STATE, m_st);
        end
        checks++;
        assert (lamp_vec === lamps(m_st)) else begin
            errors++;
            $error("FAIL model_lamps edge %0d: got %b want %b", edge_no, lamp_vec, lamps(m_st));
        end
    endtask

    task automatic run_to(input int target, input bit c, input bit p);
        while (edge_no < target) step(c, p, 1'b1);
    endtask

    task automatic expect_state(input string tag, input logic [2:0] want);
        checks++;
        assert (STATE === want) else begin
            errors++;
            $error("FAIL %s edge %0d: got %0d want %0d", tag, edge_no, STATE, want);
        end
    endtask

    task automatic expect_lamps(input string tag, input logic [6:0] want);
        checks++;
        assert (lamp_vec === want) else begin
            errors++;
            $error("FAIL %s edge %0d: got %b want %b", tag, edge_no, lamp_vec, want);
        end
    endtask

    initial begin
        // Idle: reset 5 cycles, then 100 quiet cycles in main green.
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        expect_state("reset_state", 3'd0);
        expect_lamps("reset_lamps", 7'b1000010);
        run_to(100, 0, 0);
        expect_state("idle_state", 3'd0);
        expect_lamps("idle_lamps", 7'b1000010);

        // Single car pulse at edge 2.
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 0, 1);
        run_to(7, 0, 0);  expect_state("car_min_grn_hold", 3'd0);
        run_to(8, 0, 0);  expect_state("car_main_ylw", 3'd1);
        run_to(11, 0, 0); expect_state("car_all_red1", 3'd2);
        run_to(12, 0, 0); expect_state("car_all_red1_hold", 3'd2);
        run_to(13, 0, 0); expect_state("car_side_grn", 3'd3);
        checks++;
        assert (dut.car_pend_q === 1'b0) else begin
            errors++;
            $error("FAIL car_pend_clear edge %0d: got %b want 0", edge_no, dut.car_pend_q);
        end
        run_to(18, 0, 0); expect_state("car_side_ylw", 3'd4);
        run_to(21, 0, 0); expect_state("car_all_red2", 3'd5);
        run_to(23, 0, 0); expect_state("car_back_main", 3'd0);
        run_to(40, 0, 0); expect_state("car_stays_main", 3'd0);

        // Car and pedestrian together: side green first, then walk.
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 1, 1);
        run_to(21, 0, 0); expect_state("both_all_red2", 3'd5);
        run_to(23, 0, 0); expect_state("both_walk", 3'd6);
        expect_lamps("both_walk_lamps", 7'b0010011);
        run_to(26, 0, 0); expect_state("both_walk_hold", 3'd6);
        run_to(27, 0, 0); expect_state("both_back_main", 3'd0);

        // Pedestrian only, after minimum green has elapsed.
        step(0, 0, 0);
        run_to(19, 0, 0);
        step(0, 1, 1);
        expect_state("ped_latched_still_grn", 3'd0);
        run_to(21, 0, 0); expect_state("ped_main_ylw", 3'd1);
        run_to(24, 0, 0); expect_state("ped_all_red1", 3'd2);
        run_to(26, 0, 0); expect_state("ped_walk", 3'd6);
        run_to(30, 0, 0); expect_state("ped_back_main", 3'd0);

        // Car held high from edge 2 to 30: relatched in all-red, served again at 31.
        step(0, 0, 0);
        step(0, 0, 1);
        run_to(13, 1, 0); expect_state("hold_side_grn", 3'd3);
        run_to(23, 1, 0); expect_state("hold_back_main", 3'd0);
        run_to(30, 1, 0); expect_state("hold_min_grn", 3'd0);
        run_to(31, 0, 0); expect_state("hold_second_ylw", 3'd1);

        // Reset during side green with a pending pedestrian discards it.
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 1, 1);
        run_to(15, 0, 0); expect_state("rst_mid_side_grn", 3'd3);
        step(0, 0, 0);
        expect_state("rst_mid_state", 3'd0);
        expect_lamps("rst_mid_lamps", 7'b1000010);
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 1);
            checks++;
            assert (STATE !== 3'd6) else begin
                errors++;
                $error("FAIL rst_no_walk edge %0d: got %0d want not 6", edge_no, STATE);
            end
        end

        // Random requests with occasional resets against the reference model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 599) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
